store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of store-buffer entries (power of two, >=2).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port st_valid, input, 1, store request present.
REQ-005 SHALL have port st_ready, output, 1, buffer can accept a request.
REQ-006 SHALL have port st_control, input, 3, store-control code (`SB/`SH/`SW/`STR_NOP from processor_defines.sv).
REQ-007 SHALL have port st_base, input, 32, rs1 register value.
REQ-008 SHALL have port st_imm, input, 12, signed store offset.
REQ-009 SHALL have port st_data, input, 32, rs2 register value.
REQ-010 SHALL have port mem_req, output, 1, memory write request.
REQ-011 SHALL have port mem_addr, output, 32, word-aligned write address, bits [1:0]=0.
REQ-012 SHALL have port mem_wdata, output, 32, lane-aligned write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables, bit i = byte lane i.
REQ-014 SHALL have port mem_ack, input, 1, memory accepted the current write.
REQ-015 SHALL have port buf_empty, output, 1, no store pending (fence support).
REQ-016 SHALL have port misalign, output, 1, misaligned-store pulse; present only when STORE_MISALIGN_TRAP_EN is defined.

Function
REQ-017 SHALL compute ea = st_base + sign_extend(st_imm), modulo 2^32; lane = ea[1:0].
REQ-018 SHALL encode `SB as be = 4'b0001<<lane and wdata = {4{st_data[7:0]}}.
REQ-019 SHALL encode `SH as be = 4'b0011<<{lane[1],1'b0} and wdata = {2{st_data[15:0]}}.
REQ-020 SHALL encode `SW as be = 4'b1111 and wdata = st_data.
REQ-021 SHALL enqueue {ea[31:2],2'b00, wdata, be} on st_valid&&st_ready; `STR_NOP and undefined codes SHALL be accepted and discarded, with no entry written.
REQ-022 SHALL drive st_ready = (count != DEPTH); no push-through on full, even with a simultaneous mem_ack.
REQ-023 SHALL implement FSM IDLE/REQ: IDLE->REQ when count!=0 or a push occurs; REQ->IDLE when mem_ack and count after pop/push is 0; otherwise remain in REQ.
REQ-024 SHALL drive mem_req = (state==REQ), and SHALL drive mem_addr/mem_wdata/mem_be from the FIFO head, stable while mem_req && !mem_ack.
REQ-025 SHALL pop the head on the cycle mem_req && mem_ack; back-to-back entries SHALL issue on consecutive cycles with no bubble.
REQ-026 SHALL have latency: a store accepted in cycle N into an empty buffer SHALL present mem_req in cycle N+1.
REQ-027 SHALL support simultaneous push and pop: count unchanged and order preserved; pointers SHALL wrap modulo DEPTH.
REQ-028 SHALL ignore mem_ack while mem_req is low.
REQ-029 SHALL drive buf_empty = (count==0).

Reset
REQ-030 SHALL, on a clk edge with rst_n=0, set count=0, pointers=0, state=IDLE, all entries=0, misalign=0.
REQ-031 SHALL, during reset, drive mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_ready=0, buf_empty=1.
REQ-032 SHALL, when reset is asserted mid-transaction, drop the in-flight request and discard all buffered stores; mem_req SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-033 SHALL, with STORE_MISALIGN_TRAP_EN defined, treat `SH with ea[0]=1 and `SW with ea[1:0]!=0 as misaligned: such a store is accepted but not enqueued, and misalign pulses high for exactly one cycle after acceptance.
REQ-034 SHALL, without STORE_MISALIGN_TRAP_EN, omit the misalign port and enqueue misaligned stores using the truncated lane rules of REQ-019/REQ-020.

Verification
REQ-035 SHALL cover: `SB, base=0x1000, imm=0x003, data=0xAABBCCDD -> next cycle mem_req=1, addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD.
REQ-036 SHALL cover: `SH, base=0x2000, imm=0xFFE (-2), data=0x1234 -> addr=0x1FFC, be=4'b1100, wdata=0x12341234.
REQ-037 SHALL cover: DEPTH=2 with mem_ack held low and three `SW requests -> st_ready=0 after two accepts; one mem_ack -> exactly one slot frees and the third enqueues in order.
REQ-038 SHALL cover: mem_ack held high with a stream of 4 `SW -> 4 consecutive mem_req/ack cycles in order, then buf_empty=1 and state IDLE.
REQ-039 SHALL cover: `SW, ea=0x1002 with macro -> no memory write and misalign=1 for one cycle; without macro -> addr=0x1000, be=4'b1111.
REQ-040 SHALL cover: reset asserted while mem_req=1 with 2 entries pending -> next cycle mem_req=0, buf_empty=1, and no further writes issue.

Source files
------------

// File: rtl/store_unit.sv
// Store buffer: turns SB/SH/SW requests into word-aligned, lane-steered memory writes through a DEPTH-entry FIFO.
// Latency: a store accepted into an empty buffer raises mem_req on the next cycle; queued entries issue back-to-back.
// Backpressure: st_ready drops while the FIFO is full; mem_req is held with a stable head entry until mem_ack.
// Optional: define STORE_MISALIGN_TRAP_EN to drop misaligned SH/SW stores and pulse the misalign output instead.

`ifndef STR_NOP
`define STR_NOP 3'b000
`endif
`ifndef SB
`define SB 3'b001
`endif
`ifndef SH
`define SH 3'b010
`endif
`ifndef SW
`define SW 3'b011
`endif

module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_control,
  input  logic [31:0] st_base,
  input  logic [11:0] st_imm,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        buf_empty
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  entry_t          fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  state_t          state;
  state_t          state_nxt;

  logic [31:0]     ea;
  logic [1:0]      lane;
  entry_t          enc;
  logic            enc_known;
  logic            push;
  logic            wr_en;
  logic            pop;
  entry_t          head;

`ifdef STORE_MISALIGN_TRAP_EN
  logic            mis_store;
`endif

  assign ea   = st_base + {{20{st_imm[11]}}, st_imm};
  assign lane = ea[1:0];

  // Decode the store control into a word address, replicated lane data and byte enables.
  always_comb begin
    enc       = '0;
    enc_known = 1'b0;
    enc.addr  = {ea[31:2], 2'b00};
    case (st_control)
      `SB: begin
        enc_known = 1'b1;
        enc.be    = 4'b0001 << lane;
        enc.wdata = {4{st_data[7:0]}};
      end
      `SH: begin
        enc_known = 1'b1;
        enc.be    = 4'b0011 << {lane[1], 1'b0};
        enc.wdata = {2{st_data[15:0]}};
      end
      `SW: begin
        enc_known = 1'b1;
        enc.be    = 4'b1111;
        enc.wdata = st_data;
      end
      default: begin
        enc_known = 1'b0;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  // Flag halfwords on an odd byte and words off a word boundary.
  always_comb begin
    mis_store = 1'b0;
    case (st_control)
      `SH:     mis_store = ea[0];
      `SW:     mis_store = (lane != 2'b00);
      default: mis_store = 1'b0;
    endcase
  end
`endif

  assign st_ready  = rst_n && (count != CNT_FULL);
  assign push      = st_valid && st_ready;
`ifdef STORE_MISALIGN_TRAP_EN
  assign wr_en     = push && enc_known && !mis_store;
`else
  assign wr_en     = push && enc_known;
`endif
  assign mem_req   = rst_n && (state == REQ);
  assign pop       = mem_req && mem_ack;
  assign head      = fifo_mem[rd_ptr];
  assign mem_addr  = rst_n ? head.addr  : 32'h0;
  assign mem_wdata = rst_n ? head.wdata : 32'h0;
  assign mem_be    = rst_n ? head.be    : 4'h0;
  assign buf_empty = !rst_n || (count == '0);

  // Occupancy after this cycle's write and pop; a full buffer never writes, so no overflow.
  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Request FSM: leave IDLE as soon as anything is buffered, return once the last entry is acked.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((count != '0) || wr_en) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack && (count_nxt == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage, pointers and occupancy; reset clears every entry so outputs start at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        fifo_mem[wr_ptr] <= enc;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  // One-cycle pulse following acceptance of a dropped misaligned store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= push && mis_store;
    end
  end
`endif

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios followed by random traffic.
// Expected writes come from a queue-based reference model fed by the store encoding rules.
// Every cycle compares handshake, occupancy and head-of-queue outputs against that model.

`ifndef STR_NOP
`define STR_NOP 3'b000
`endif
`ifndef SB
`define SB 3'b001
`endif
`ifndef SH
`define SH 3'b010
`endif
`ifndef SW
`define SW 3'b011
`endif

module tb_store_unit;

  localparam int DEPTH = 2;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_control;
  logic [31:0] st_base;
  logic [11:0] st_imm;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        buf_empty;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_control (st_control),
    .st_base    (st_base),
    .st_imm     (st_imm),
    .st_data    (st_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .buf_empty  (buf_empty)
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  bit  mis_exp;
  int  vectors;
  int  miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding straight from the store rules, using arithmetic rather than bit steering.
  function automatic bit model_encode(input logic [2:0] ctrl, input logic [31:0] base,
                                      input logic [11:0] imm, input logic [31:0] data,
                                      output wr_t w, output bit mis);
    int          off;
    logic [31:0] ea;
    int          ln;
    off    = $signed(imm);
    ea     = base + 32'(off);
    ln     = int'(ea % 4);
    w.addr = ea - (ea % 4);
    w.wdata = '0;
    w.be    = '0;
    mis     = 1'b0;
    case (ctrl)
      `SB: begin
        w.be    = 4'(1 << ln);
        w.wdata = {24'h0, data[7:0]} * 32'h0101_0101;
        return 1'b1;
      end
      `SH: begin
        w.be    = (ln >= 2) ? 4'b1100 : 4'b0011;
        w.wdata = {16'h0, data[15:0]} * 32'h0001_0001;
        mis     = (ln % 2) != 0;
        return 1'b1;
      end
      `SW: begin
        w.be    = 4'b1111;
        w.wdata = data;
        mis     = (ln != 0);
        return 1'b1;
      end
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic cycle(input bit v, input logic [2:0] ctrl, input logic [31:0] base,
                       input logic [11:0] imm, input logic [31:0] data, input bit ack,
                       input bit rstn);
    bit  exp_req;
    bit  exp_rdy;
    bit  acc;
    bit  popq;
    bit  known;
    bit  mis;
    wr_t w;
    st_valid   = v;
    st_control = ctrl;
    st_base    = base;
    st_imm     = imm;
    st_data    = data;
    mem_ack    = ack;
    rst_n      = rstn;
    #1;
    exp_req = rstn && (exp_q.size() != 0);
    exp_rdy = rstn && (exp_q.size() != DEPTH);
    chk("st_ready", {31'h0, st_ready}, {31'h0, exp_rdy});
    chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
    chk("buf_empty", {31'h0, buf_empty}, {31'h0, (!rstn || exp_q.size() == 0)});
    if (exp_req) begin
      chk("head_addr", mem_addr, exp_q[0].addr);
      chk("head_wdata", mem_wdata, exp_q[0].wdata);
      chk("head_be", {28'h0, mem_be}, {28'h0, exp_q[0].be});
    end else if (!rstn) begin
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_be", {28'h0, mem_be}, 32'h0);
    end
`ifdef STORE_MISALIGN_TRAP_EN
    chk("misalign", {31'h0, misalign}, {31'h0, mis_exp});
`endif
    acc  = v && exp_rdy;
    popq = exp_req && ack;
    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
      mis_exp = 1'b0;
    end else begin
      mis_exp = 1'b0;
      if (popq) void'(exp_q.pop_front());
      if (acc) begin
        known = model_encode(ctrl, base, imm, data, w, mis);
        if (known) begin
          if (MIS_EN && mis) mis_exp = 1'b1;
          else exp_q.push_back(w);
        end
      end
    end
    #1;
  endtask

  task automatic idle(input bit ack);
    cycle(1'b0, `STR_NOP, 32'h0, 12'h0, 32'h0, ack, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mis_exp     = 1'b0;

    // Reset values held for a couple of cycles.
    cycle(1'b0, `STR_NOP, 32'h0, 12'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, `SW, 32'h40, 12'h0, 32'h1, 1'b1, 1'b0);
    idle(1'b0);

    // Byte store to lane 3, presented the cycle after acceptance.
    cycle(1'b1, `SB, 32'h0000_1000, 12'h003, 32'hAABB_CCDD, 1'b0, 1'b1);
    chk("sb_req", {31'h0, mem_req}, 32'h1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_be", {28'h0, mem_be}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    idle(1'b0);
    idle(1'b1);

    // Halfword with a negative offset.
    cycle(1'b1, `SH, 32'h0000_2000, 12'hFFE, 32'h0000_1234, 1'b0, 1'b1);
    chk("sh_addr", mem_addr, 32'h0000_1FFC);
    chk("sh_be", {28'h0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    idle(1'b1);

    // NOP and an undefined code are accepted but write nothing.
    cycle(1'b1, `STR_NOP, 32'h300, 12'h0, 32'h5, 1'b0, 1'b1);
    cycle(1'b1, 3'b111, 32'h300, 12'h0, 32'h5, 1'b0, 1'b1);
    chk("nop_empty", {31'h0, buf_empty}, 32'h1);
    chk("nop_req", {31'h0, mem_req}, 32'h0);

    // Fill to capacity with ack low, then free exactly one slot.
    cycle(1'b1, `SW, 32'h100, 12'h0, 32'hA0A0_A0A0, 1'b0, 1'b1);
    cycle(1'b1, `SW, 32'h104, 12'h0, 32'hB1B1_B1B1, 1'b0, 1'b1);
    chk("full_rdy", {31'h0, st_ready}, 32'h0);
    cycle(1'b1, `SW, 32'h108, 12'h0, 32'hC2C2_C2C2, 1'b0, 1'b1);
    chk("full_rdy_hold", {31'h0, st_ready}, 32'h0);
    cycle(1'b1, `SW, 32'h108, 12'h0, 32'hC2C2_C2C2, 1'b1, 1'b1);
    chk("one_free", {31'h0, st_ready}, 32'h1);
    cycle(1'b1, `SW, 32'h108, 12'h0, 32'hC2C2_C2C2, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Stream of words with ack held high.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, `SW, 32'h200 + 32'(4 * i), 12'h0, 32'h0F0F_0000 + 32'(i), 1'b1, 1'b1);
    end
    idle(1'b1);
    chk("stream_empty", {31'h0, buf_empty}, 32'h1);
    chk("stream_idle", {31'h0, mem_req}, 32'h0);

    // Misaligned word store.
    cycle(1'b1, `SW, 32'h0000_1000, 12'h002, 32'h7654_3210, 1'b0, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_nowrite", {31'h0, mem_req}, 32'h0);
    idle(1'b0);
    chk("mis_clear", {31'h0, misalign}, 32'h0);
`else
    chk("mis_addr", mem_addr, 32'h0000_1000);
    chk("mis_be", {28'h0, mem_be}, 32'hF);
    idle(1'b1);
`endif

    // Reset in the middle of a pending transaction.
    cycle(1'b1, `SW, 32'h400, 12'h0, 32'h1111_1111, 1'b0, 1'b1);
    cycle(1'b1, `SW, 32'h404, 12'h0, 32'h2222_2222, 1'b0, 1'b1);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    cycle(1'b0, `STR_NOP, 32'h0, 12'h0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_req", {31'h0, mem_req}, 32'h0);
    chk("post_rst_empty", {31'h0, buf_empty}, 32'h1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("no_more_writes", {31'h0, mem_req}, 32'h0);

    // Random traffic, including occasional resets and unaligned addresses.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
            12'($urandom), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("final_empty", {31'h0, buf_empty}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
